// File: rtl/arb_pkg.sv
// Shared types and defaults for the round-robin burst arbiter/merge.
package arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam int DEF_N_REQ      = 9;
  localparam int DEF_DATA_WIDTH = 12;
  localparam int DEF_MAX_BURST  = 4;

  // Width of a requester index; never below one bit.
  function automatic int src_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: first set req bit at or after ptr, wrapping at N.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N = DEF_N_REQ,
  parameter int W = src_w(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         any,
  output logic [W-1:0] idx,
  output logic [N-1:0] onehot
);

  logic       found;
  logic [W:0] j;

  always_comb begin
    any    = |req;
    idx    = '0;
    onehot = '0;
    found  = 1'b0;
    j      = '0;
    for (int k = 0; k < N; k++) begin
      // ptr < N, so a single subtract brings ptr+k back into range.
      j = {1'b0, ptr} + (W+1)'(k);
      if (j >= (W+1)'(N)) j = j - (W+1)'(N);
      if (!found && req[j[W-1:0]]) begin
        found = 1'b1;
        idx   = j[W-1:0];
      end
    end
    if (found) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/rr_burst_arb_merge.sv
// N-to-1 round-robin merge holding a grant for a whole burst (up to MAX_BURST
// beats or the requester's last beat), with one registered output stage.
module rr_burst_arb_merge
  import arb_pkg::*;
#(
  parameter int N_REQ      = DEF_N_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_BURST  = DEF_MAX_BURST,
  localparam int SRC_W     = src_w(N_REQ)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            i_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0] i_data,
  input  logic [N_REQ-1:0]            i_last,
  output logic [N_REQ-1:0]            o_ready,
  output logic                        o_valid,
  output logic [DATA_WIDTH-1:0]       o_data,
  output logic [SRC_W-1:0]            o_src,
  output logic                        o_last,
  input  logic                        i_ready
);

  // Handshake: a beat moves on an edge where valid and ready are both high on
  // the same side; producers hold valid/data/last stable until they see ready.
  state_t                state, state_nxt;
  logic [SRC_W-1:0]      ptr, ptr_nxt;
  logic [SRC_W-1:0]      own, own_nxt;
  logic [3:0]            cnt, cnt_nxt;

  logic                  load_en;
  logic                  any;
  logic                  accept;
  logic                  sel_last;
  logic [SRC_W-1:0]      pick_idx;
  logic [SRC_W-1:0]      sel_idx;
  logic [N_REQ-1:0]      pick_onehot;
  logic [DATA_WIDTH-1:0] sel_data;

  function automatic logic [SRC_W-1:0] next_idx(input logic [SRC_W-1:0] x);
    return (x == SRC_W'(N_REQ - 1)) ? '0 : x + SRC_W'(1);
  endfunction

  rr_pick #(
    .N (N_REQ),
    .W (SRC_W)
  ) u_pick (
    .req    (i_valid),
    .ptr    (ptr),
    .any    (any),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  assign load_en  = ~o_valid | i_ready;
  assign sel_idx  = (state == LOCKED) ? own : pick_idx;
  assign sel_data = i_data[int'(sel_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign sel_last = i_last[sel_idx];
  assign accept   = ~rst & load_en & ((state == LOCKED) ? i_valid[own] : any);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      own   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      own   <= own_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    own_nxt   = own;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (sel_last || MAX_BURST == 1) begin
            ptr_nxt = next_idx(sel_idx);
          end else begin
            state_nxt = LOCKED;
            own_nxt   = sel_idx;
            cnt_nxt   = 4'd1;
          end
        end
      end
      LOCKED: begin
        if (accept) begin
          if (sel_last || cnt == 4'(MAX_BURST - 1)) begin
            state_nxt = IDLE;
            ptr_nxt   = next_idx(own);
            cnt_nxt   = 4'd0;
          end else begin
            cnt_nxt = cnt + 4'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // While locked the owner sees ready even with valid low; no one else is served.
  always_comb begin
    o_ready = '0;
    if (!rst && load_en) begin
      if (state == LOCKED) o_ready[own] = 1'b1;
      else if (any)        o_ready      = pick_onehot;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_src   <= '0;
      o_last  <= 1'b0;
    end else if (load_en) begin
      if (accept) begin
        o_valid <= 1'b1;
        o_data  <= sel_data;
        o_src   <= sel_idx;
        o_last  <= sel_last;
      end else begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_burst_arb_merge.sv
// Bench for rr_burst_arb_merge: cycle model + beat scoreboard, table scenarios
// and hand-written corner sequences.
module tb_rr_burst_arb_merge;

  localparam int N  = 9;
  localparam int DW = 12;
  localparam int MB = 4;
  localparam int SW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    i_valid;
  logic [N*DW-1:0] i_data;
  logic [N-1:0]    i_last;
  logic [N-1:0]    o_ready;
  logic            o_valid;
  logic [DW-1:0]   o_data;
  logic [SW-1:0]   o_src;
  logic            o_last;
  logic            i_ready;

  rr_burst_arb_merge #(
    .N_REQ      (N),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .i_valid (i_valid),
    .i_data  (i_data),
    .i_last  (i_last),
    .o_ready (o_ready),
    .o_valid (o_valid),
    .o_data  (o_data),
    .o_src   (o_src),
    .o_last  (o_last),
    .i_ready (i_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end, got timeout required finish");
    $fatal(1);
  end

  // ---------------- bench state ----------------
  logic [DW:0]    mem [N][16];
  int             len [N];
  int             pos [N];
  logic [N-1:0]   hold;
  logic           rdy_next, rst_next;
  int             acc_k;
  logic [SW+DW:0] exp_q [$];
  int             obs [64];
  int             nobs;
  int             nvec, nerr;

  // reference model
  bit m_state;
  bit m_ov;
  int m_ptr, m_own, m_cnt;

  typedef struct {
    logic [8:0][3:0] plen;
    int              reps;
    bit              rnd_rdy;
    int              exp_n;
    logic [63:0]     exp_src;
  } vec_t;

  vec_t vecs [3];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 1'b0;
    m_ov    = 1'b0;
    m_ptr   = 0;
    m_own   = 0;
    m_cnt   = 0;
  endtask

  task automatic clear_all();
    for (int k = 0; k < N; k++) begin
      len[k] = 0;
      pos[k] = 0;
    end
    hold = '0;
  endtask

  task automatic add_pkt(input int k, input int n);
    for (int b = 0; b < n; b++)
      mem[k][len[k]+b] = {(b == n - 1), DW'($urandom_range(0, 4095))};
    len[k] += n;
  endtask

  task automatic clear_obs();
    nobs = 0;
    for (int i = 0; i < 64; i++) obs[i] = -1;
  endtask

  task automatic drive();
    i_ready = rdy_next;
    rst     = rst_next;
    for (int k = 0; k < N; k++) begin
      if (pos[k] < len[k] && !hold[k]) begin
        i_valid[k]          = 1'b1;
        i_data[k*DW +: DW]  = mem[k][pos[k]][DW-1:0];
        i_last[k]           = mem[k][pos[k]][DW];
      end else begin
        i_valid[k] = 1'b0;
        i_last[k]  = 1'b0;
      end
    end
  endtask

  // Called mid-cycle: compares the DUT against the model, then advances the
  // model across the coming rising edge.
  task automatic evaluate();
    logic           load;
    logic [N-1:0]   er;
    logic [SW+DW:0] e;
    int             w, j;
    bit             acc, found;
    load  = !m_ov || i_ready;
    er    = '0;
    acc   = 1'b0;
    found = 1'b0;
    w     = 0;
    if (!rst) begin
      if (!m_state) begin
        for (int d = 0; d < N; d++) begin
          j = (m_ptr + d) % N;
          if (!found && i_valid[j]) begin
            found = 1'b1;
            w     = j;
          end
        end
        acc = found && load;
        if (acc) er[w] = 1'b1;
      end else begin
        w = m_own;
        if (load) er[w] = 1'b1;
        acc = load && i_valid[w];
      end
    end
    chk("o_ready", o_ready, er);
    chk("o_valid", o_valid, m_ov);
    if (o_valid && i_ready) begin
      if (exp_q.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL sb_empty: got beat src %0d expected no beat", o_src);
      end else begin
        e = exp_q.pop_front();
        chk("beat", {o_src, o_last, o_data}, e);
      end
      if (nobs < 64) begin
        obs[nobs] = o_src;
        nobs++;
      end
    end
    if (rst) begin
      model_reset();
      exp_q.delete();
    end else begin
      if (load) begin
        if (acc) begin
          m_ov = 1'b1;
          exp_q.push_back({SW'(w), i_last[w], i_data[w*DW +: DW]});
          acc_k = w;
        end else begin
          m_ov = 1'b0;
        end
      end
      if (acc) begin
        if (!m_state) begin
          if (i_last[w] || MB == 1) m_ptr = (w + 1) % N;
          else begin
            m_state = 1'b1;
            m_own   = w;
            m_cnt   = 1;
          end
        end else begin
          if (i_last[w] || m_cnt == MB - 1) begin
            m_state = 1'b0;
            m_ptr   = (w + 1) % N;
          end else begin
            m_cnt++;
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (acc_k >= 0) pos[acc_k]++;
    acc_k = -1;
    drive();
    @(negedge clk);
    evaluate();
  endtask

  function automatic bit done();
    bit d;
    d = !m_ov && exp_q.size() == 0 && acc_k < 0;
    for (int k = 0; k < N; k++) if (pos[k] < len[k]) d = 1'b0;
    return d;
  endfunction

  task automatic run(input bit rnd, input int max);
    int n;
    n = 0;
    while (!done() && n < max) begin
      rdy_next = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      n++;
    end
    rdy_next = 1'b1;
    if (!done()) begin
      nvec++;
      nerr++;
      $display("FAIL run_timeout: got unfinished traffic after %0d cycles required completion", n);
    end
  endtask

  task automatic do_reset();
    rst_next = 1'b1;
    tick();
    tick();
    rst_next = 1'b0;
  endtask

  task automatic chk_seq(input string nm, input int n, input logic [63:0] s);
    for (int i = 0; i < n; i++) chk(nm, obs[i], {28'd0, s[4*i +: 4]});
  endtask

  task automatic wait_acc(input int k, input int cnt_needed);
    int n, seen;
    n    = 0;
    seen = 0;
    while (seen < cnt_needed && n < 20) begin
      tick();
      if (acc_k == k) seen++;
      n++;
    end
    if (seen < cnt_needed) begin
      nvec++;
      nerr++;
      $display("FAIL wait_acc: got %0d beats from req %0d required %0d", seen, k, cnt_needed);
    end
  endtask

  initial begin
    nvec     = 0;
    nerr     = 0;
    acc_k    = -1;
    rst      = 1'b1;
    rst_next = 1'b1;
    i_ready  = 1'b1;
    rdy_next = 1'b1;
    i_valid  = '0;
    i_last   = '0;
    i_data   = '0;
    clear_all();
    clear_obs();
    model_reset();

    vecs[0] = '{plen: 36'h111111111, reps: 2, rnd_rdy: 1'b0, exp_n: 10, exp_src: 64'h0876543210};
    vecs[1] = '{plen: 36'h000206000, reps: 1, rnd_rdy: 1'b0, exp_n: 8,  exp_src: 64'h33553333};
    vecs[2] = '{plen: 36'h701030050, reps: 2, rnd_rdy: 1'b1, exp_n: 16, exp_src: 64'h4441888864441111};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_o_valid", o_valid, 0);
    chk("rst_o_ready", o_ready, 0);
    chk("rst_o_src",   o_src,   0);
    chk("rst_o_data",  o_data,  0);
    chk("rst_o_last",  o_last,  0);

    for (int v = 0; v < 3; v++) begin
      clear_all();
      for (int k = 0; k < N; k++)
        for (int r = 0; r < vecs[v].reps; r++)
          if (vecs[v].plen[k] != 0) add_pkt(k, int'(vecs[v].plen[k]));
      do_reset();
      clear_obs();
      run(vecs[v].rnd_rdy, 600);
      chk_seq($sformatf("vec%0d_src", v), vecs[v].exp_n, vecs[v].exp_src);
    end

    // Backpressure: output held five cycles with i_ready low.
    clear_all();
    add_pkt(2, 3);
    do_reset();
    clear_obs();
    for (int n = 0; n < 10 && !m_ov; n++) tick();
    rdy_next = 1'b0;
    repeat (5) begin
      tick();
      chk("bp_o_ready", o_ready, 0);
      chk("bp_o_valid", o_valid, 1);
      chk("bp_o_src",   o_src,   2);
    end
    run(1'b0, 50);
    chk_seq("bp_src", 3, 64'h222);

    // Owner drops valid while locked; req 7 must wait.
    clear_all();
    add_pkt(2, 4);
    add_pkt(7, 2);
    do_reset();
    clear_obs();
    wait_acc(2, 1);
    hold[2] = 1'b1;
    repeat (3) begin
      tick();
      chk("lock_o_ready7", o_ready[7], 0);
    end
    hold[2] = 1'b0;
    run(1'b0, 50);
    chk_seq("lock_src", 6, 64'h772222);

    // Reset mid-burst at cnt=2, then arbitration restarts from ptr=0.
    clear_all();
    add_pkt(4, 6);
    do_reset();
    wait_acc(4, 2);
    rst_next = 1'b1;
    tick();
    chk("midrst_o_ready", o_ready, 0);
    rst_next = 1'b0;
    clear_obs();
    add_pkt(1, 1);
    tick();
    chk("midrst_o_valid", o_valid, 0);
    run(1'b0, 50);
    chk_seq("midrst_src", 5, 64'h44441);

    // Pointer wrap from 8 to 0.
    clear_all();
    add_pkt(7, 1);
    do_reset();
    clear_obs();
    run(1'b0, 20);
    add_pkt(8, 1);
    add_pkt(0, 1);
    run(1'b0, 20);
    chk_seq("wrap_src", 3, 64'h087);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
